// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: strobes the columns of a 4x4 matrix keypad, samples the
// rows, debounces whole-frame results and emits one key code per press.
// Accepted digits are shifted into a 16-bit register for the display path.
//
// Optional macro KEYPAD_HEX_MAP_EN: when defined, raw {row,col} positions are
// translated to the standard hex keypad legend; otherwise codes are raw.
//
// Output handshake: key_valid_o is a single-cycle strobe with no ready/back-
// pressure; key_code_o and reg_16_o are already updated in the strobe cycle
// and key_code_o holds its value until the next strobe.
module keypad_scanner #(
   parameter int SCAN_PERIOD    = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  row_i,
   input  logic        clear_i,
   output logic [3:0]  col_o,
   output logic [3:0]  key_code_o,
   output logic        key_valid_o,
   output logic        key_held_o,
   output logic [15:0] reg_16_o,
   output logic [1:0]  dbg_state_o
);

   localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_PERIOD - 1);
   localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       col_idx;
   logic             sample;
   logic             frame_end;

   logic [2:0]       col_hits;
   logic [1:0]       col_row;
   logic [1:0]       acc_cnt;
   logic [3:0]       acc_key;
   logic [1:0]       frm_cnt;
   logic [3:0]       frm_key;
   logic             res_none;
   logic             res_single;

   state_t           state;
   state_t           state_nxt;
   logic [DB_W-1:0]  cnt;
   logic [DB_W-1:0]  cnt_nxt;
   logic [DB_W-1:0]  cnt_inc;
   logic [3:0]       cand;
   logic [3:0]       cand_nxt;
   logic             accept;
   logic [3:0]       accept_code;

   // Raw position -> user-visible key code.
   function automatic logic [3:0] map_key(input logic [3:0] raw);
`ifdef KEYPAD_HEX_MAP_EN
      logic [3:0] code;
      case (raw)
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
`else
      return raw;
`endif
   endfunction

   // Two-flop synchroniser for the asynchronous row lines (idle = all high).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_i;
         row_sync <= row_meta;
      end
   end

   assign sample    = (scan_cnt == SCAN_LAST);
   assign frame_end = sample && (col_idx == 2'd3);
   assign col_o     = ~(4'b0001 << col_idx);

   // Count low rows on the current column and combine with earlier columns.
   always_comb begin
      col_hits = 3'd0;
      col_row  = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_sync[r]) begin
            col_hits = col_hits + 3'd1;
            col_row  = 2'(r);
         end
      end
      // acc_cnt/frm_cnt: 0 = none, 1 = single, 2 = two or more
      if ((acc_cnt == 2'd2) || (col_hits >= 3'd2) ||
          ((acc_cnt == 2'd1) && (col_hits == 3'd1)))
         frm_cnt = 2'd2;
      else if ((acc_cnt == 2'd1) || (col_hits == 3'd1))
         frm_cnt = 2'd1;
      else
         frm_cnt = 2'd0;
      frm_key = (acc_cnt == 2'd1) ? acc_key : {col_row, col_idx};
   end

   assign res_none   = (frm_cnt == 2'd0);
   assign res_single = (frm_cnt == 2'd1);

   // Column dwell counter, column index and per-frame hit accumulator.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scan_cnt <= '0;
         col_idx  <= 2'd0;
         acc_cnt  <= 2'd0;
         acc_key  <= 4'd0;
      end else if (sample) begin
         scan_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
         if (frame_end) begin
            acc_cnt <= 2'd0;
            acc_key <= 4'd0;
         end else begin
            acc_cnt <= frm_cnt;
            acc_key <= frm_key;
         end
      end else begin
         scan_cnt <= scan_cnt + CNT_W'(1);
      end
   end

   // FSM state register with debounce counter and candidate key.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
         cand  <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cand  <= cand_nxt;
      end
   end

   // FSM next-state: moves only on a frame-end result.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cand_nxt  = cand;
      accept    = 1'b0;
      cnt_inc   = cnt + DB_W'(1);
      if (frame_end) begin
         case (state)
            ST_IDLE: begin
               if (res_single) begin
                  cand_nxt = frm_key;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_nxt = ST_PRESSED;
                     cnt_nxt   = '0;
                     accept    = 1'b1;
                  end else begin
                     state_nxt = ST_DEBOUNCE;
                     cnt_nxt   = DB_W'(1);
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (res_single && (frm_key == cand)) begin
                  if (cnt_inc == DB_TARGET) begin
                     state_nxt = ST_PRESSED;
                     cnt_nxt   = '0;
                     accept    = 1'b1;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end
            end
            ST_PRESSED: begin
               // Other keys or multi-key frames are ignored: no rollover.
               if (res_none) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = ST_RELEASE;
                     cnt_nxt   = DB_W'(1);
                  end
               end
            end
            ST_RELEASE: begin
               if (res_none) begin
                  if (cnt_inc == DB_TARGET) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else if (res_single && (frm_key == cand)) begin
                  state_nxt = ST_PRESSED;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = '0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // FSM outputs: key held while pressed or while the release is debounced.
   always_comb begin
      key_held_o  = (state == ST_PRESSED) || (state == ST_RELEASE);
      dbg_state_o = state;
   end

   assign accept_code = map_key(cand_nxt);

   // Accept strobe, last key code and the digit shift register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         key_valid_o <= 1'b0;
         key_code_o  <= 4'd0;
         reg_16_o    <= 16'h0000;
      end else begin
         key_valid_o <= accept;
         if (accept)
            key_code_o <= accept_code;
         if (clear_i)
            reg_16_o <= accept ? {12'h000, accept_code} : 16'h0000;
         else if (accept)
            reg_16_o <= {reg_16_o[11:0], accept_code};
      end
   end

endmodule
